// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmit and keyboard receive paths:
// FSM states, default timing at 50 MHz, and frame constants.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    WAIT_IDLE,
    FAIL
  } ps2_state_t;

  localparam int INHIBIT_CYCLES_DEF       = 5000;    // 100 us
  localparam int START_TIMEOUT_CYCLES_DEF = 750000;  // 15 ms
  localparam int XFER_TIMEOUT_CYCLES_DEF  = 100000;  // 2 ms

  localparam int CNT_W      = 20;
  localparam int BIT_CNT_W  = 4;
  localparam int HOST_FALLS = 10;  // 8 data + parity + stop, all host-driven
  localparam int FRAME_W    = 10;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer and falling-edge detector for one PS/2 line.
// Flops reset to 1 (idle bus level) so reset release never fakes a fall.
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic line_in,
  output logic line_s,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= line_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign line_s = sync_p1;
  assign fall   = prev_p2 & ~sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts one
// byte plus odd parity and stop out on device-generated clock falls.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = INHIBIT_CYCLES_DEF,
  parameter int START_TIMEOUT_CYCLES = START_TIMEOUT_CYCLES_DEF,
  parameter int XFER_TIMEOUT_CYCLES  = XFER_TIMEOUT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [CNT_W-1:0]     INH_LAST     = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     START_LAST   = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     XFER_LAST    = CNT_W'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT_CNT = BIT_CNT_W'(HOST_FALLS - 2);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ps2_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [FRAME_W-1:0]   frame;
  logic                 clk_s;
  logic                 clk_fall;
  logic                 dat_s;
  logic                 dat_fall_unused;
  logic                 accept;
  logic                 shift_en;
  logic                 go_fail;

  ps2_line_sync u_clk_sync (
    .clock   (clock),
    .reset   (reset),
    .line_in (ps2_clk_in),
    .line_s  (clk_s),
    .fall    (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clock   (clock),
    .reset   (reset),
    .line_in (ps2_dat_in),
    .line_s  (dat_s),
    .fall    (dat_fall_unused)
  );

  assign accept   = (state == IDLE) && send;
  assign shift_en = clk_fall && ((state == REQ) || (state == BITS));

  always_comb begin
    go_fail = 1'b0;
    case (state)
      REQ:             go_fail = !clk_fall && (cnt == START_LAST);
      BITS, WAIT_IDLE: go_fail = (cnt >= XFER_LAST);
      ACK:             go_fail = (cnt >= XFER_LAST) || (clk_fall && dat_s);
      default:         go_fail = 1'b0;
    endcase
  end

  // Frame is {stop, parity, data}; bit 0 is always the next bit to drive.
  always_ff @(posedge clock) begin
    if (accept) begin
      frame <= {1'b1, odd_parity(data_in), data_in};
    end else if (shift_en) begin
      frame <= {1'b1, frame[FRAME_W-1:1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cnt        <= '0;
      bit_cnt    <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (send) begin
            state      <= INHIBIT;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            cnt        <= '0;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            state      <= REQ;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        REQ: begin
          cnt <= sat_inc(cnt);
          // First device fall: drive data bit 0 and start the transfer timer.
          if (clk_fall) begin
            state      <= BITS;
            ps2_dat_oe <= ~frame[0];
            bit_cnt    <= '0;
            cnt        <= '0;
          end
        end
        BITS: begin
          cnt <= sat_inc(cnt);
          if (clk_fall) begin
            ps2_dat_oe <= ~frame[0];
            bit_cnt    <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT_CNT) begin
              state <= ACK;
            end
          end
        end
        ACK: begin
          cnt <= sat_inc(cnt);
          if (clk_fall) begin
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          cnt <= sat_inc(cnt);
          if (clk_s && dat_s) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FAIL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (go_fail) begin
        state      <= FAIL;
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b0;
        error      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus model with a PS/2 device that
// clocks at a 40-cycle period, table-driven frames plus corner sequences.
module tb_ps2_host_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       error;
  logic       ps2_clk_line;
  logic       ps2_dat_line;

  assign ps2_clk_line = ~ps2_clk_oe & dev_clk;
  assign ps2_dat_line = ~ps2_dat_oe & dev_dat;

  always #5 clock = ~clock;

  ps2_host_tx #(
    .INHIBIT_CYCLES       (20),
    .START_TIMEOUT_CYCLES (200),
    .XFER_TIMEOUT_CYCLES  (2000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .send       (send),
    .data_in    (data_in),
    .ps2_clk_in (ps2_clk_line),
    .ps2_dat_in (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && (done || error)) begin
      if (done) done_cnt++;
      if (error) err_cnt++;
      chk("busy_low_on_pulse", busy, 0);
      chk("done_error_exclusive", done & error, 0);
    end
  end

  task automatic start_send(input logic [7:0] d, output int inh);
    @(posedge clock); #1;
    send = 1'b1;
    data_in = d;
    @(posedge clock); #1;
    send = 1'b0;
    data_in = 8'hA5;
    inh = 0;
    while (ps2_clk_oe === 1'b1 && inh < 1000) begin
      inh++;
      @(posedge clock); #1;
    end
  endtask

  // Device: 11 falls at a 40-cycle period; samples the host bit late in each
  // low phase, optionally pulls data low ahead of fall 11 as acknowledge.
  task automatic device_xfer(input bit ack, input int abort_at, output logic [9:0] frame);
    frame = '0;
    repeat (10) @(posedge clock);
    #1;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) begin
        if (ack) dev_dat = 1'b0;
        repeat (5) @(posedge clock);
        #1;
      end
      dev_clk = 1'b0;
      if (i == abort_at) begin
        repeat (5) @(posedge clock);
        #1;
        return;
      end
      repeat (19) @(posedge clock);
      #1;
      if (i <= 10) frame = {ps2_dat_line, frame[9:1]};
      @(posedge clock); #1;
      dev_clk = 1'b1;
      if (i == 11) dev_dat = 1'b1;
      repeat (20) @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic [9:0] exp_frame;  // bit 0 = value on fall 1
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int inh;
    int n;
    int d0;
    int e0;
    logic [9:0] frame;

    vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1, 0};
    vecs[1] = '{8'h07, 1'b1, 10'h207, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 10'h300, 1, 0};
    vecs[3] = '{8'h55, 1'b0, 10'h355, 0, 1};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_clk_oe", ps2_clk_oe, 0);
    chk("reset_dat_oe", ps2_dat_oe, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      start_send(vecs[v].data, inh);
      chk($sformatf("inhibit_len[%0d]", v), inh, 20);
      chk($sformatf("start_bit[%0d]", v), ps2_dat_oe, 1);
      chk($sformatf("busy_req[%0d]", v), busy, 1);
      device_xfer(vecs[v].ack, 0, frame);
      wait_idle(n);
      chk($sformatf("completes[%0d]", v), n < 500, 1);
      chk($sformatf("frame[%0d]", v), frame, vecs[v].exp_frame);
      chk($sformatf("done_pulses[%0d]", v), done_cnt - d0, vecs[v].exp_done);
      chk($sformatf("error_pulses[%0d]", v), err_cnt - e0, vecs[v].exp_err);
      chk($sformatf("lines_released[%0d]", v), {ps2_clk_oe, ps2_dat_oe}, 0);
      repeat (5) @(posedge clock);
      #1;
    end

    // Device never clocks: start timeout counted from REQ entry.
    d0 = done_cnt;
    e0 = err_cnt;
    start_send(8'h3C, inh);
    chk("inhibit_len_to", inh, 20);
    n = 0;
    while (!error && n < 1000) begin
      @(posedge clock); #1;
      n++;
    end
    chk("start_timeout_cycles", n, 200);
    chk("to_lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
    chk("to_busy", busy, 0);
    repeat (5) @(posedge clock);
    #1;
    chk("to_error_pulses", err_cnt - e0, 1);
    chk("to_done_pulses", done_cnt - d0, 0);

    // send pulsed mid-transfer is ignored and not queued.
    d0 = done_cnt;
    e0 = err_cnt;
    start_send(8'hFF, inh);
    fork
      device_xfer(1'b1, 0, frame);
      begin
        repeat (150) @(posedge clock);
        #1;
        send = 1'b1;
        data_in = 8'h55;
        @(posedge clock); #1;
        send = 1'b0;
      end
    join
    wait_idle(n);
    chk("mid_send_frame", frame, 10'h3FF);
    repeat (100) @(posedge clock);
    #1;
    chk("mid_send_not_queued_busy", busy, 0);
    chk("mid_send_not_queued_clk", ps2_clk_oe, 0);
    chk("mid_send_done_pulses", done_cnt - d0, 1);
    chk("mid_send_error_pulses", err_cnt - e0, 0);

    // Asynchronous reset while the device holds its clock low at fall 5.
    d0 = done_cnt;
    e0 = err_cnt;
    start_send(8'hED, inh);
    device_xfer(1'b1, 5, frame);
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_dat_oe", ps2_dat_oe, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_clk_oe", ps2_clk_oe, 0);
    chk("async_reset_dat_oe", ps2_dat_oe, 0);
    chk("async_reset_busy", busy, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("reset_no_error", err_cnt - e0, 0);
    chk("reset_no_done", done_cnt - d0, 0);
    start_send(8'h07, inh);
    chk("post_reset_inhibit", inh, 20);
    device_xfer(1'b1, 0, frame);
    wait_idle(n);
    chk("post_reset_frame", frame, 10'h207);
    chk("post_reset_done", done_cnt - d0, 1);
    chk("post_reset_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
